// File: rtl/snoop_responder_if.sv
// Snoop responder bus bundle: snoop channel from the arbitrator,
// writeback channel to memory and tag/state array port.
// Ports: master = arbitrator/cache/memory side, slave = responder side.
interface snoop_responder_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 4
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    logic               snoop_valid;
    logic [ADDR_W-1:0]  snoop_addr;
    logic               snoop_is_write;
    logic               snoop_ack;
    logic               snoop_hit;
    logic               busy;

    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               wb_ready;

    logic               arr_req;
    logic               arr_gnt;
    logic               arr_we;
    logic [INDEX_W-1:0] arr_idx;
    logic [1:0]         arr_state_wr;
    logic [TAG_W-1:0]   arr_tag;
    logic [1:0]         arr_state;
    logic [DATA_W-1:0]  arr_data;

    modport slave (
        input  snoop_valid, snoop_addr, snoop_is_write,
        input  wb_ready, arr_gnt, arr_tag, arr_state, arr_data,
        output snoop_ack, snoop_hit, busy,
        output wb_valid, wb_addr, wb_data,
        output arr_req, arr_we, arr_idx, arr_state_wr
    );

    modport master (
        output snoop_valid, snoop_addr, snoop_is_write,
        output wb_ready, arr_gnt, arr_tag, arr_state, arr_data,
        input  snoop_ack, snoop_hit, busy,
        input  wb_valid, wb_addr, wb_data,
        input  arr_req, arr_we, arr_idx, arr_state_wr
    );
endinterface

// File: rtl/snoop_responder.sv
// MSI snoop target: looks up the local line, writes back M data,
// downgrades/invalidates, then acks. Ports: clk, rst, bus (slave).
module snoop_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 4
) (
    input logic              clk,
    input logic              rst,
    snoop_responder_if.slave bus
);
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [2:0] {
        IDLE, REQ, LOOKUP, WB, UPDATE, ACK
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        new_q;
    logic              hit_q;

    logic accept;
    logic tag_match;
    logic is_s;
    logic is_m;
    logic hit;

    always_comb begin
        accept    = (state == IDLE) && bus.snoop_valid;
        tag_match = bus.arr_tag == addr_q[ADDR_W-1:INDEX_W];
        // encoding 11 falls through both compares and reads as I
        is_s      = bus.arr_state == ST_S;
        is_m      = bus.arr_state == ST_M;
        hit       = tag_match && (is_s || is_m);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
            new_q  <= ST_I;
            hit_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q <= bus.snoop_addr;
                wr_q   <= bus.snoop_is_write;
            end
            if (state == LOOKUP) begin
                hit_q <= hit;
                // S lines only ever go to I; M lines downgrade on a read
                new_q <= (is_m && !wr_q) ? ST_S : ST_I;
                if (is_m) data_q <= bus.arr_data;
            end
        end
    end

    always_comb begin
        state_n          = state;
        bus.snoop_ack    = 1'b0;
        bus.snoop_hit    = 1'b0;
        bus.busy         = state != IDLE;
        bus.wb_valid     = 1'b0;
        bus.wb_addr      = addr_q;
        bus.wb_data      = data_q;
        bus.arr_req      = 1'b0;
        bus.arr_we       = 1'b0;
        bus.arr_idx      = addr_q[INDEX_W-1:0];
        bus.arr_state_wr = ST_I;
        unique case (state)
            IDLE: begin
                if (bus.snoop_valid) state_n = REQ;
            end
            REQ: begin
                bus.arr_req = 1'b1;
                if (bus.arr_gnt) state_n = LOOKUP;
            end
            LOOKUP: begin
                if (!hit)      state_n = ACK;
                else if (is_m) state_n = WB;
                else if (wr_q) state_n = UPDATE;
                else           state_n = ACK;
            end
            WB: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) state_n = UPDATE;
            end
            UPDATE: begin
                bus.arr_req      = 1'b1;
                bus.arr_we       = 1'b1;
                bus.arr_state_wr = new_q;
                if (bus.arr_gnt) state_n = ACK;
            end
            ACK: begin
                bus.snoop_ack = 1'b1;
                bus.snoop_hit = hit_q;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with a behavioural
// tag/state array and a writeback sink with programmable delay.
module tb_snoop_responder;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snoop_responder_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)
    ) bus ();

    snoop_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [3:0] m_tag  [16];
    logic [1:0] m_st   [16];
    logic [7:0] m_data [16];

    logic       cfg_we;
    logic [3:0] cfg_idx;
    logic [3:0] cfg_tag;
    logic [1:0] cfg_st;
    logic [7:0] cfg_data;

    logic gnt_en;
    int   wb_delay;
    int   wb_cnt;

    int pass_cnt;
    int total;

    assign bus.arr_gnt  = gnt_en;
    assign bus.wb_ready = (wb_cnt >= wb_delay);

    always @(posedge clk) begin
        if (cfg_we) begin
            m_tag[cfg_idx]  <= cfg_tag;
            m_st[cfg_idx]   <= cfg_st;
            m_data[cfg_idx] <= cfg_data;
        end else if (bus.arr_req && bus.arr_gnt && bus.arr_we) begin
            m_st[bus.arr_idx] <= bus.arr_state_wr;
        end
        if (bus.arr_req && bus.arr_gnt && !bus.arr_we) begin
            bus.arr_tag   <= m_tag[bus.arr_idx];
            bus.arr_state <= m_st[bus.arr_idx];
            bus.arr_data  <= m_data[bus.arr_idx];
        end
        if (!bus.wb_valid) wb_cnt <= 0;
        else               wb_cnt <= wb_cnt + 1;
    end

    task automatic set_line(input logic [3:0] idx, input logic [3:0] tg,
                            input logic [1:0] st, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_tag = tg;
        cfg_st = st;   cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Drives one snoop and records what happened; lat=-1 on timeout.
    task automatic do_snoop(
        input  logic [7:0] a,
        input  logic       w,
        output int         lat,
        output logic       hit,
        output logic       saw_we,
        output logic [1:0] we_st,
        output logic [3:0] we_idx,
        output int         wb_n,
        output logic [7:0] wb_a,
        output logic [7:0] wb_d,
        output logic       wb_stable
    );
        lat = -1; hit = 1'b0; saw_we = 1'b0;
        we_st = 2'b11; we_idx = '0;
        wb_n = 0; wb_a = '0; wb_d = '0; wb_stable = 1'b1;
        @(negedge clk);
        bus.snoop_valid    = 1'b1;
        bus.snoop_addr     = a;
        bus.snoop_is_write = w;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.snoop_addr     = ~a;
                bus.snoop_is_write = ~w;
            end
            if (bus.arr_req && bus.arr_gnt && bus.arr_we) begin
                saw_we = 1'b1;
                we_st  = bus.arr_state_wr;
                we_idx = bus.arr_idx;
            end
            if (bus.wb_valid) begin
                if (wb_n > 0 && (bus.wb_addr != wb_a ||
                                 bus.wb_data != wb_d))
                    wb_stable = 1'b0;
                wb_a = bus.wb_addr;
                wb_d = bus.wb_data;
                wb_n++;
            end
            if (bus.snoop_ack) begin
                lat = n;
                hit = bus.snoop_hit;
                bus.snoop_valid = 1'b0;
                break;
            end
        end
        bus.snoop_valid = 1'b0;
    endtask

    int         lat;
    logic       hit, saw_we, wb_stable;
    logic [1:0] we_st;
    logic [3:0] we_idx;
    int         wb_n;
    logic [7:0] wb_a, wb_d;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.snoop_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", bus.snoop_ack);
        else pass_cnt++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else pass_cnt++;
        total++;
        if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid);
        else pass_cnt++;
        total++;
        if (bus.arr_req !== 1'b0) $display("FAIL reset_arr_req got %b want 0", bus.arr_req);
        else pass_cnt++;
        total++;
        if ({bus.wb_addr, bus.wb_data, bus.arr_idx, bus.arr_state_wr,
             bus.arr_we, bus.snoop_hit} !== '0)
            $display("FAIL reset_buses got %h/%h/%h/%b want 0",
                     bus.wb_addr, bus.wb_data, bus.arr_idx, bus.arr_state_wr);
        else pass_cnt++;
    endtask

    task automatic test_miss();
        set_line(4'd5, 4'd2, 2'b01, 8'h11);
        do_snoop(8'h35, 1'b0, lat, hit, saw_we, we_st, we_idx,
                 wb_n, wb_a, wb_d, wb_stable);
        total++;
        if (lat !== 3) $display("FAIL miss_latency got %0d want 3", lat);
        else pass_cnt++;
        total++;
        if (hit !== 1'b0) $display("FAIL miss_hit got %b want 0", hit);
        else pass_cnt++;
        total++;
        if (saw_we || wb_n != 0)
            $display("FAIL miss_side_effects got we=%b wb=%0d want 0/0", saw_we, wb_n);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (bus.snoop_ack !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL ack_pulse got ack=%b busy=%b want 0/0", bus.snoop_ack, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_s_read();
        set_line(4'd5, 4'd3, 2'b01, 8'h22);
        do_snoop(8'h35, 1'b0, lat, hit, saw_we, we_st, we_idx,
                 wb_n, wb_a, wb_d, wb_stable);
        total++;
        if (lat !== 3) $display("FAIL s_read_latency got %0d want 3", lat);
        else pass_cnt++;
        total++;
        if (hit !== 1'b1) $display("FAIL s_read_hit got %b want 1", hit);
        else pass_cnt++;
        total++;
        if (saw_we || wb_n != 0 || m_st[5] !== 2'b01)
            $display("FAIL s_read_no_change got we=%b wb=%0d st=%b want 0/0/01",
                     saw_we, wb_n, m_st[5]);
        else pass_cnt++;
    endtask

    task automatic test_s_write();
        do_snoop(8'h35, 1'b1, lat, hit, saw_we, we_st, we_idx,
                 wb_n, wb_a, wb_d, wb_stable);
        total++;
        if (lat !== 4) $display("FAIL s_write_latency got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if (hit !== 1'b1) $display("FAIL s_write_hit got %b want 1", hit);
        else pass_cnt++;
        total++;
        if (!saw_we || we_idx !== 4'd5 || we_st !== 2'b00)
            $display("FAIL s_write_update got we=%b idx=%0d st=%b want 1/5/00",
                     saw_we, we_idx, we_st);
        else pass_cnt++;
        total++;
        if (m_st[5] !== 2'b00 || wb_n != 0)
            $display("FAIL s_write_state got st=%b wb=%0d want 00/0", m_st[5], wb_n);
        else pass_cnt++;
    endtask

    task automatic test_m_read();
        set_line(4'd5, 4'd3, 2'b10, 8'hA7);
        wb_delay = 2;
        do_snoop(8'h35, 1'b0, lat, hit, saw_we, we_st, we_idx,
                 wb_n, wb_a, wb_d, wb_stable);
        wb_delay = 0;
        total++;
        if (lat !== 7) $display("FAIL m_read_latency got %0d want 7", lat);
        else pass_cnt++;
        total++;
        if (hit !== 1'b1) $display("FAIL m_read_hit got %b want 1", hit);
        else pass_cnt++;
        total++;
        if (wb_n != 3 || !wb_stable)
            $display("FAIL m_read_wb_hold got cycles=%0d stable=%b want 3/1", wb_n, wb_stable);
        else pass_cnt++;
        total++;
        if (wb_a !== 8'h35 || wb_d !== 8'hA7)
            $display("FAIL m_read_wb_payload got %h/%h want 35/a7", wb_a, wb_d);
        else pass_cnt++;
        total++;
        if (we_st !== 2'b01 || m_st[5] !== 2'b01)
            $display("FAIL m_read_downgrade got wr=%b st=%b want 01/01", we_st, m_st[5]);
        else pass_cnt++;
    endtask

    task automatic test_gnt_stall();
        logic stall_ok;
        int   l;
        set_line(4'd5, 4'd3, 2'b01, 8'h33);
        gnt_en = 1'b0;
        @(negedge clk);
        bus.snoop_valid = 1'b1; bus.snoop_addr = 8'h35;
        bus.snoop_is_write = 1'b0;
        @(posedge clk);
        stall_ok = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (!(bus.arr_req && bus.busy && !bus.snoop_ack && !bus.arr_we))
                stall_ok = 1'b0;
        end
        gnt_en = 1'b1;
        total++;
        if (stall_ok !== 1'b1) $display("FAIL gnt_stall got ok=%b want 1", stall_ok);
        else pass_cnt++;
        l = -1;
        for (int n = 7; n <= 30; n++) begin
            @(negedge clk);
            if (bus.snoop_ack) begin
                l = n; hit = bus.snoop_hit; break;
            end
        end
        bus.snoop_valid = 1'b0;
        total++;
        if (l !== 8 || hit !== 1'b1)
            $display("FAIL gnt_resume got lat=%0d hit=%b want 8/1", l, hit);
        else pass_cnt++;
    endtask

    task automatic test_rst_in_wb();
        logic seen;
        set_line(4'd5, 4'd3, 2'b10, 8'h5C);
        wb_delay = 100;
        @(negedge clk);
        bus.snoop_valid = 1'b1; bus.snoop_addr = 8'h35;
        bus.snoop_is_write = 1'b0;
        @(posedge clk);
        seen = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.wb_valid) begin seen = 1'b1; break; end
        end
        total++;
        if (seen !== 1'b1) $display("FAIL rst_wb_entry got %b want 1", seen);
        else pass_cnt++;
        rst = 1'b1;
        bus.snoop_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.snoop_ack, bus.snoop_hit, bus.busy, bus.wb_valid,
             bus.wb_addr, bus.wb_data, bus.arr_req, bus.arr_we,
             bus.arr_idx, bus.arr_state_wr} !== '0)
            $display("FAIL rst_outputs got wbv=%b busy=%b req=%b addr=%h want 0",
                     bus.wb_valid, bus.busy, bus.arr_req, bus.wb_addr);
        else pass_cnt++;
        rst = 1'b0;
        wb_delay = 0;
        total++;
        if (m_st[5] !== 2'b10) $display("FAIL rst_no_write got %b want 10", m_st[5]);
        else pass_cnt++;
        do_snoop(8'h35, 1'b1, lat, hit, saw_we, we_st, we_idx,
                 wb_n, wb_a, wb_d, wb_stable);
        total++;
        if (lat !== 5 || hit !== 1'b1)
            $display("FAIL rst_fresh got lat=%0d hit=%b want 5/1", lat, hit);
        else pass_cnt++;
        total++;
        if (wb_n != 1 || wb_d !== 8'h5C || we_st !== 2'b00)
            $display("FAIL rst_fresh_wb got n=%0d d=%h st=%b want 1/5c/00",
                     wb_n, wb_d, we_st);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total = 0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_tag = '0;
        cfg_st = '0; cfg_data = '0;
        gnt_en = 1'b1; wb_delay = 0;
        bus.snoop_valid = 1'b0; bus.snoop_addr = '0;
        bus.snoop_is_write = 1'b0;
        rst = 1'b1;
        test_reset();
        test_miss();
        test_s_read();
        test_s_write();
        test_m_read();
        test_gnt_stall();
        test_rst_in_wb();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
